conv_window_mac: RTL and testbench
==================================

# conv_window_mac

Control-and-datapath stage that drives the window address decoder. It walks every output pixel of an N×N result and every tap of the K×K kernel, and passes each (kernel index, pixel number) pair to the decoder. It issues the resulting flat address to the input-feature buffer and the tap index to the weight buffer. For each output pixel it multiplies and accumulates the K*K returned pairs, then hands the sum downstream over a valid/ready port.

## Interface
- K, 3, kernel side; K*K taps per pixel
- N, 2, output side; N*N output pixels
- DW, 8, signed input and weight width
- AW, 2*DW+$clog2(K*K), signed accumulator and output width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a convolution; sampled only in IDLE
- stride  in  $clog2(K)  window step; latched when start is accepted
- busy  out  1  high from start acceptance through the done cycle
- done  out  1  one-cycle pulse after the last output handshake
- cfg_err  out  1  one-cycle pulse when start is rejected for stride > K
- feat_addr  out  $clog2(N*N*K*K)  flat input-buffer address (the decoder's decoded_index)
- w_addr  out  $clog2(K*K)  weight-buffer address (the current tap index)
- rd_en  out  1  read strobe for both buffers
- feat_rdata  in  DW  signed feature; valid the cycle after rd_en
- w_rdata  in  DW  signed weight; valid the cycle after rd_en
- out_valid  out  1  output pixel available
- out_ready  in  1  downstream accepts the output pixel
- out_pixel  out  $clog2(N*N)  index of the pixel being output
- out_data  out  AW  signed convolution sum

## Operation
- FSM states: IDLE, FETCH, DRAIN, EMIT, FIN.
- **IDLE:**
  - If start=1 and stride≤K: latch stride, clear pix and tap, go to FETCH.
  - If start=1 and stride>K: pulse cfg_err and stay in IDLE.
- **FETCH:**
  - rd_en=1, w_addr=tap, feat_addr=decoder(tap, pix, stride_q).
  - tap increments each cycle.
  - When tap=K*K-1, reset tap to 0 and go to DRAIN.
- **DRAIN:** rd_en=0; the last product accumulates; go to EMIT.
- **Accumulation pipeline:**
  - A registered flag acc_v (a one-cycle-delayed rd_en) qualifies the returned data.
  - Product = signed DW×DW, sign-extended to AW.
  - On the first product of a pixel, acc is loaded with that product; on later products, acc += product.
  - acc wraps modulo 2^AW; there is no saturation.
- **EMIT:**
  - out_valid=1; out_data=acc and out_pixel=pix are held stable until out_ready=1.
  - On the handshake: if pix=N*N-1, go to FIN; otherwise pix+1 and go to FETCH.
- **FIN:** done=1 for one cycle, then IDLE. busy=1 in every state except IDLE.
- **Pixel order:** pixels 0..N*N-1 in order. Taps 0..K*K-1 in order, row-major (tap/K is the row, tap%K is the column), matching the decoder.
- **Rule precedence:**
  - start while busy is ignored.
  - In FIN, start is ignored; it is accepted only from IDLE on the following cycle.
  - rst_n low at any time aborts immediately. The partial sum is discarded and no done is produced.

## Timing
- **Reset values:** busy, done, cfg_err, rd_en, out_valid = 0; feat_addr, w_addr, out_pixel, out_data = 0; FSM = IDLE; acc = 0.
- **Cycle numbering:** start is accepted at the edge closing cycle 0.
- **First pixel:**
  - rd_en is high in cycles 1..K*K.
  - Data returns in cycles 2..K*K+1; the last return coincides with DRAIN.
  - out_valid first rises in cycle K*K+2.
- **Pixel period:** K*K+2 cycles when out_ready is held high; each extra out_ready-low cycle adds one cycle.
- **Full run (K=3, N=2, out_ready=1):**
  - out_valid in cycles 11, 22, 33, 44.
  - done in cycle 45; busy falls in cycle 46.
- Buffers have fixed one-cycle read latency; no backpressure exists on the read side.
- feat_addr and w_addr are combinational from registered tap, pix and stride_q; there are no combinational paths from inputs to outputs.

## Structure
- **Shared package conv_pkg:**
  - FSM state enum.
  - Localparams KK=K*K, NN=N*N, ADDR_W=$clog2(N*N*K*K).
  - AW default function.
- **Sub-module:** one instance of the existing decoder (K, N passed through). Its kernel_width input is tied to K.
- **Local logic:** counters, FSM and MAC. No other sub-modules.

## Test plan
- **Identity weights, stride 1:**
  - Setup: K=3, N=2, feat[a]=a, all weights=1, stride=1, out_ready=1.
  - Required: outputs (pixel, data) = (0,63), (1,72), (2,117), (3,126).
  - Required: pixel-0 feat_addr sequence 0,1,2,6,7,8,12,13,14.
  - Required: done in cycle 45.
- **Stride 2, same data:** pixel 3 = 189 and pixel 3 addresses start at 14.
- **Signed extremes:** all feat=-128 and all weights=-128 → every out_data=147456; all weights=+127 → every out_data=-146304.
- **Backpressure:** out_ready low for 5 cycles at pixel 1 → out_data and out_pixel stable, next rd_en delayed by exactly 5 cycles, sums unchanged.
- **Rejected start:**
  - stride=3 with K=2 → cfg_err pulses, busy stays 0.
  - start re-pulsed mid-run → ignored, output sequence unchanged.
- **Reset mid-run:** rst_n low during pixel 2 FETCH → all outputs 0 asynchronously, no done. A new start then produces the full correct sequence from pixel 0.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and sizing helpers for conv_window_mac
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_EMIT,
        ST_FIN
    } state_t;

    localparam int K_DEF  = 3;
    localparam int N_DEF  = 2;
    localparam int DW_DEF = 8;

    localparam int KK     = K_DEF * K_DEF;
    localparam int NN     = N_DEF * N_DEF;
    localparam int ADDR_W = $clog2(NN * KK);

    // Accumulator holds K*K full-width products without overflow.
    function automatic int aw_default(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_window_mac_decoder.sv
// rtl/conv_window_mac_decoder.sv - maps (tap, output pixel, stride) to a flat input-buffer address
module conv_window_mac_decoder
    import conv_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int N  = N_DEF,
    parameter int SW = $clog2(K)
) (
    input  logic [$clog2(K*K)-1:0]     kernel_index,
    input  logic [$clog2(N*N)-1:0]     pixel,
    input  logic [SW-1:0]              stride,
    input  logic [$clog2(K+1)-1:0]     kernel_width,
    output logic [$clog2(N*N*K*K)-1:0] decoded_index
);

    localparam int ADDR_BITS = $clog2(N * N * K * K);

    int kw;
    int row;
    int col;

    // Input image is (N*kw) pixels wide; taps are row-major within the window.
    always_comb begin
        kw            = (kernel_width == '0) ? 1 : int'(kernel_width);
        row           = (int'(pixel) / N) * int'(stride) + int'(kernel_index) / kw;
        col           = (int'(pixel) % N) * int'(stride) + int'(kernel_index) % kw;
        decoded_index = ADDR_BITS'(row * (N * kw) + col);
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - walks every pixel/tap pair, fetches operands and accumulates one sum per output pixel
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = aw_default(DW, K),
    parameter int SW = $clog2(K)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [SW-1:0]                 stride,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic [$clog2(N*N*K*K)-1:0]    feat_addr,
    output logic [$clog2(K*K)-1:0]        w_addr,
    output logic                          rd_en,
    input  logic signed [DW-1:0]          feat_rdata,
    input  logic signed [DW-1:0]          w_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(N*N)-1:0]        out_pixel,
    output logic signed [AW-1:0]          out_data
);

    localparam int TAPS   = K * K;
    localparam int PIXELS = N * N;
    localparam int TW     = $clog2(TAPS);
    localparam int PW     = $clog2(PIXELS);
    localparam int KWW    = $clog2(K + 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [PW-1:0]        pix_q, pix_d;
    logic [SW-1:0]        stride_q, stride_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 acc_v_q, acc_v_d;
    logic                 acc_first_q, acc_first_d;
    logic signed [AW-1:0] acc_q, acc_d;

    logic                     stride_bad;
    logic signed [2*DW-1:0]   prod;
    logic signed [AW-1:0]     prod_ext;

    assign stride_bad = 32'(stride) > 32'(K);
    assign prod       = feat_rdata * w_rdata;
    assign prod_ext   = {{(AW-2*DW){prod[2*DW-1]}}, prod};

    conv_window_mac_decoder #(
        .K  (K),
        .N  (N),
        .SW (SW)
    ) u_decoder (
        .kernel_index  (tap_q),
        .pixel         (pix_q),
        .stride        (stride_q),
        .kernel_width  (KWW'(K)),
        .decoded_index (feat_addr)
    );

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        pix_d       = pix_q;
        stride_d    = stride_q;
        cfg_err_d   = 1'b0;
        acc_v_d     = (state_q == ST_FETCH);
        acc_first_d = (state_q == ST_FETCH) && (tap_q == '0);
        acc_d       = acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (stride_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        stride_d = stride;
                        tap_d    = '0;
                        pix_d    = '0;
                        state_d  = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (tap_q == TW'(TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_EMIT;
            ST_EMIT: begin
                if (out_ready) begin
                    if (pix_q == PW'(PIXELS - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        pix_d   = pix_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Data returned one cycle after each read; the first tap restarts the sum.
        if (acc_v_q) begin
            acc_d = acc_first_q ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            pix_q       <= '0;
            stride_q    <= '0;
            cfg_err_q   <= 1'b0;
            acc_v_q     <= 1'b0;
            acc_first_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            pix_q       <= pix_d;
            stride_q    <= stride_d;
            cfg_err_q   <= cfg_err_d;
            acc_v_q     <= acc_v_d;
            acc_first_q <= acc_first_d;
            acc_q       <= acc_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign rd_en     = (state_q == ST_FETCH);
    assign out_valid = (state_q == ST_EMIT);
    assign cfg_err   = cfg_err_q;
    assign w_addr    = tap_q;
    assign out_pixel = pix_q;
    assign out_data  = acc_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - self-checking bench for conv_window_mac
module tb_conv_window_mac;
    import conv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, busy, done, cfg_err, rd_en, out_valid, out_ready;
    logic [1:0]         stride;
    logic [5:0]         feat_addr;
    logic [3:0]         w_addr;
    logic [1:0]         out_pixel;
    logic signed [7:0]  feat_rdata, w_rdata;
    logic signed [19:0] out_data;

    logic               start2, busy2, done2, cfg_err2, rd_en2, out_valid2, out_ready2;
    logic [1:0]         stride2;
    logic [3:0]         feat_addr2;
    logic [1:0]         w_addr2;
    logic [1:0]         out_pixel2;
    logic signed [7:0]  feat_rdata2, w_rdata2;
    logic signed [17:0] out_data2;

    conv_window_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .busy(busy), .done(done),
        .cfg_err(cfg_err), .feat_addr(feat_addr), .w_addr(w_addr), .rd_en(rd_en),
        .feat_rdata(feat_rdata), .w_rdata(w_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_data(out_data)
    );

    conv_window_mac #(.K(2), .N(2), .SW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stride(stride2), .busy(busy2), .done(done2),
        .cfg_err(cfg_err2), .feat_addr(feat_addr2), .w_addr(w_addr2), .rd_en(rd_en2),
        .feat_rdata(feat_rdata2), .w_rdata(w_rdata2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_pixel(out_pixel2), .out_data(out_data2)
    );

    logic signed [7:0] feat_mem [NN*KK];
    logic signed [7:0] w_mem [KK];

    always @(posedge clk) begin
        if (rd_en) begin
            feat_rdata <= feat_mem[int'(feat_addr)];
            w_rdata    <= w_mem[int'(w_addr)];
        end
    end

    int errors = 0;
    int checks = 0;
    int hs_pix[$], hs_data[$], hs_cyc[$], rd_addr[$], rd_w[$], rd_cyc[$];
    int done_cyc, done_cnt, busy_fall, stab_err;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int addr_of(input int p, input int t, input int s);
        return ((p / N_DEF) * s + t / K_DEF) * (N_DEF * K_DEF) + (p % N_DEF) * s + t % K_DEF;
    endfunction

    function automatic longint model_sum(input int p, input int s);
        longint sum = 0;
        for (int t = 0; t < KK; t++)
            sum += longint'(int'(feat_mem[addr_of(p, t, s)]) * int'(w_mem[t]));
        sum = sum & longint'(20'hFFFFF);
        if (sum >= (longint'(1) << 19)) sum -= (longint'(1) << 20);
        return sum;
    endfunction

    task automatic fill(input int fmode, input int wmode);
        for (int a = 0; a < NN*KK; a++)
            feat_mem[a] = (fmode == 0) ? 8'(a) : (fmode == 1) ? 8'sh80 : 8'($urandom_range(0, 255));
        for (int t = 0; t < KK; t++)
            w_mem[t] = (wmode == 0) ? 8'sd1 : (wmode == 1) ? 8'sh80 :
                       (wmode == 2) ? 8'sd127 : 8'($urandom_range(0, 255));
    endtask

    // Cycle c of a run is sampled at the falling edge inside it; start is accepted closing cycle 0.
    task automatic run_conv(input int s, input int bp_pix, input int bp_len, input int restart_cyc,
                            input bit rnd_ready);
        int bp_cnt = 0;
        bit holding = 1'b0;
        bit fin = 1'b0;
        logic [1:0] hp = '0;
        logic signed [19:0] hd = '0;
        hs_pix.delete(); hs_data.delete(); hs_cyc.delete();
        rd_addr.delete(); rd_w.delete(); rd_cyc.delete();
        done_cyc = -1; done_cnt = 0; busy_fall = -1; stab_err = 0;
        @(negedge clk);
        start = 1'b1; stride = 2'(s); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400 && !fin; c++) begin
            if (c == restart_cyc) begin start = 1'b1; stride = 2'(s + 1); end
            else start = 1'b0;
            if (holding && (out_pixel !== hp || out_data !== hd)) stab_err++;
            if (rd_en) begin
                rd_addr.push_back(int'(feat_addr)); rd_w.push_back(int'(w_addr)); rd_cyc.push_back(c);
            end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (!busy) begin busy_fall = c; fin = 1'b1; end
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && int'(out_pixel) == bp_pix && bp_cnt < bp_len) begin
                out_ready = 1'b0; bp_cnt++;
            end else out_ready = 1'b1;
            if (out_valid && out_ready) begin
                hs_pix.push_back(int'(out_pixel)); hs_data.push_back(int'(out_data)); hs_cyc.push_back(c);
            end
            holding = out_valid && !out_ready;
            hp = out_pixel; hd = out_data;
            if (!fin) @(negedge clk);
        end
        chk("run_timeout", longint'(fin), 1);
        start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        chk({tag, "_out_count"}, hs_pix.size(), 4);
        for (int j = 0; j < 4 && j < hs_pix.size(); j++) begin
            chk($sformatf("%s_pix%0d_index", tag, j), hs_pix[j], j);
            chk($sformatf("%s_pix%0d_data", tag, j), hs_data[j], ex[j]);
        end
        chk({tag, "_hold_stable"}, stab_err, 0);
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    task automatic check_addrs(input string tag, input int s);
        chk({tag, "_read_count"}, rd_addr.size(), NN*KK);
        for (int i = 0; i < rd_addr.size() && i < NN*KK; i++) begin
            chk($sformatf("%s_feat_addr%0d", tag, i), rd_addr[i], addr_of(i / KK, i % KK, s));
            chk($sformatf("%s_w_addr%0d", tag, i), rd_w[i], i % KK);
        end
    endtask

    typedef struct {
        int stride; int fmode; int wmode; int restart;
        int e0; int e1; int e2; int e3;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int p0_addr[9];
        int nd;
        vecs[0] = '{1, 0, 0, 0,  63,  72, 117, 126};
        vecs[1] = '{2, 0, 0, 0,  63,  81, 171, 189};
        vecs[2] = '{3, 0, 0, 0,  63,  90, 225, 252};
        vecs[3] = '{1, 1, 1, 0,  147456, 147456, 147456, 147456};
        vecs[4] = '{1, 1, 2, 0, -146304, -146304, -146304, -146304};
        vecs[5] = '{1, 0, 0, 15, 63,  72, 117, 126};
        p0_addr = '{0, 1, 2, 6, 7, 8, 12, 13, 14};

        rst_n = 1'b0; start = 1'b0; stride = '0; out_ready = 1'b1;
        start2 = 1'b0; stride2 = '0; out_ready2 = 1'b1; feat_rdata2 = '0; w_rdata2 = '0;
        feat_rdata = '0; w_rdata = '0;
        fill(0, 0);
        #1;
        chk("reset_busy", busy, 0);       chk("reset_done", done, 0);
        chk("reset_cfg_err", cfg_err, 0); chk("reset_rd_en", rd_en, 0);
        chk("reset_out_valid", out_valid, 0); chk("reset_feat_addr", feat_addr, 0);
        chk("reset_w_addr", w_addr, 0);   chk("reset_out_pixel", out_pixel, 0);
        chk("reset_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Out-of-range stride on a K=2 instance, then the largest legal stride.
        @(negedge clk); start2 = 1'b1; stride2 = 2'd3;
        @(negedge clk); start2 = 1'b0;
        chk("rej_cfg_err_pulse", cfg_err2, 1); chk("rej_busy", busy2, 0);
        @(negedge clk);
        chk("rej_cfg_err_clear", cfg_err2, 0); chk("rej_busy_after", busy2, 0);
        start2 = 1'b1; stride2 = 2'd2;
        @(negedge clk); start2 = 1'b0;
        chk("acc_k_stride_busy", busy2, 1); chk("acc_k_stride_cfg_err", cfg_err2, 0);

        foreach (vecs[v]) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            fill(vecs[v].fmode, vecs[v].wmode);
            run_conv(vecs[v].stride, -1, 0, vecs[v].restart, 1'b0);
            check_seq(tag, vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
            check_addrs(tag, vecs[v].stride);
            for (int j = 0; j < hs_cyc.size() && j < 4; j++)
                chk($sformatf("%s_valid_cycle%0d", tag, j), hs_cyc[j], 11 * (j + 1));
            chk({tag, "_first_rd_cycle"}, rd_cyc.size() > 0 ? rd_cyc[0] : -1, 1);
            chk({tag, "_done_cycle"}, done_cyc, 45);
            chk({tag, "_busy_fall"}, busy_fall, 46);
            if (vecs[v].stride == 1 && v == 0 && rd_addr.size() >= 9)
                for (int i = 0; i < 9; i++) chk($sformatf("p0_addr%0d", i), rd_addr[i], p0_addr[i]);
            if (vecs[v].stride == 2 && rd_addr.size() >= 28) chk("s2_p3_first_addr", rd_addr[27], 14);
        end

        // Backpressure: five out_ready-low cycles while pixel 1 is presented.
        fill(0, 0);
        run_conv(1, 1, 5, 0, 1'b0);
        check_seq("bp", 63, 72, 117, 126);
        chk("bp_pix1_handshake_cycle", hs_cyc.size() > 1 ? hs_cyc[1] : -1, 27);
        chk("bp_pix2_first_rd_cycle", rd_cyc.size() > 18 ? rd_cyc[18] : -1, 28);
        chk("bp_done_cycle", done_cyc, 50);

        // Asynchronous reset in the middle of pixel 2's fetch.
        @(negedge clk); start = 1'b1; stride = 2'd1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rd_en && out_pixel == 2'd2) break;
            @(negedge clk);
        end
        chk("mid_reached_pix2", rd_en && out_pixel == 2'd2, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);         chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_out_data", out_data, 0); chk("mid_rst_out_pixel", out_pixel, 0);
        chk("mid_rst_feat_addr", feat_addr, 0); chk("mid_rst_w_addr", w_addr, 0);
        nd = 0;
        repeat (3) begin @(negedge clk); if (done) nd++; end
        chk("mid_rst_no_done", nd, 0);
        rst_n = 1'b1;
        run_conv(1, -1, 0, 0, 1'b0);
        check_seq("after_rst", 63, 72, 117, 126);
        chk("after_rst_done_cycle", done_cyc, 45);

        // Random operands, random stride and random downstream readiness.
        for (int r = 0; r < 4; r++) begin
            int s;
            s = int'($urandom_range(0, 3));
            fill(2, 3);
            run_conv(s, -1, 0, 0, 1'b1);
            check_seq($sformatf("rnd%0d", r), int'(model_sum(0, s)), int'(model_sum(1, s)),
                      int'(model_sum(2, s)), int'(model_sum(3, s)));
            check_addrs($sformatf("rnd%0d", r), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
